// File: rtl/mem_load_ctrl.sv
// Boot-time owner of the shared instruction/data memory: streams an image in from START_ADDR,
// optionally re-reads it against a running checksum, then hands the memory ports to the CPU.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start after reset, CPU held in reset
// WRITE   | accepting stream bytes, one memory byte write per accept
// CHECK   | reading the image back one byte per cycle, summing it
// RUN     | CPU released, mem_* ports pass the CPU ports through
// ERROR   | readback sum differed from the write sum; start retries
module mem_load_ctrl #(
    parameter logic [31:0] START_ADDR = 32'h8000_0000,
    parameter int unsigned MEM_SIZE   = 8192,
    parameter bit          VERIFY     = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] load_len,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    output logic        s_ready,
    input  logic [31:0] cpu_mem_addr,
    input  logic [31:0] cpu_mem_ro_addr2,
    input  logic        cpu_mem_we,
    input  logic [1:0]  cpu_mem_write_size,
    input  logic [31:0] cpu_mem_wd,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_ro_addr2,
    output logic        mem_we,
    output logic [1:0]  mem_write_size,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd2,
    output logic        cpu_reset,
    output logic        done,
    output logic        error,
    output logic [31:0] load_count
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_CHECK = 3'd2,
        ST_RUN   = 3'd3,
        ST_ERROR = 3'd4
    } state_t;

    localparam logic [31:0] C_MEM_SIZE = 32'(MEM_SIZE);

    state_t      r_state;
    logic [31:0] r_len;
    logic [31:0] r_count;
    logic [31:0] r_wsum;
    logic [31:0] r_rsum;
    logic [31:0] r_rc;
    logic        r_done;
    logic        r_error;
    logic        r_cpu_reset;

    logic [31:0] w_len_clamp;
    logic [31:0] w_rsum_next;
    logic        w_last_wr;
    logic        w_last_rd;
    logic        w_unused_rd2;

    assign w_len_clamp  = (load_len > C_MEM_SIZE) ? C_MEM_SIZE : load_len;
    assign w_rsum_next  = r_rsum + {24'b0, mem_rd2[7:0]};
    assign w_last_wr    = (r_count == r_len - 32'd1);
    assign w_last_rd    = (r_rc == r_len - 32'd1);
    assign w_unused_rd2 = ^mem_rd2[31:8];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_len       <= '0;
            r_count     <= '0;
            r_wsum      <= '0;
            r_rsum      <= '0;
            r_rc        <= '0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_cpu_reset <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE, ST_ERROR: begin
                    if (start) begin
                        r_len   <= w_len_clamp;
                        r_count <= '0;
                        r_wsum  <= '0;
                        r_rsum  <= '0;
                        r_rc    <= '0;
                        r_error <= 1'b0;
                        if (w_len_clamp == 32'd0) begin
                            r_state     <= ST_RUN;
                            r_done      <= 1'b1;
                            r_cpu_reset <= 1'b0;
                        end else begin
                            r_state <= ST_WRITE;
                        end
                    end
                end
                ST_WRITE: begin
                    if (s_valid) begin
                        r_count <= r_count + 32'd1;
                        r_wsum  <= r_wsum + {24'b0, s_data};
                        if (w_last_wr) begin
                            if (VERIFY) begin
                                r_state <= ST_CHECK;
                            end else begin
                                r_state     <= ST_RUN;
                                r_done      <= 1'b1;
                                r_cpu_reset <= 1'b0;
                            end
                        end
                    end
                end
                ST_CHECK: begin
                    r_rsum <= w_rsum_next;
                    r_rc   <= r_rc + 32'd1;
                    // the final compare must include the byte read in this same cycle
                    if (w_last_rd) begin
                        if (w_rsum_next == r_wsum) begin
                            r_state     <= ST_RUN;
                            r_done      <= 1'b1;
                            r_cpu_reset <= 1'b0;
                        end else begin
                            r_state <= ST_ERROR;
                            r_error <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    r_state <= ST_RUN;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        s_ready        = 1'b0;
        mem_addr       = START_ADDR;
        mem_ro_addr2   = START_ADDR;
        mem_we         = 1'b0;
        mem_write_size = 2'd0;
        mem_wd         = '0;
        case (r_state)
            ST_WRITE: begin
                s_ready  = 1'b1;
                mem_we   = s_valid;
                mem_addr = START_ADDR + r_count;
                mem_wd   = {24'b0, s_data};
            end
            ST_CHECK: begin
                mem_ro_addr2 = START_ADDR + r_rc;
            end
            ST_RUN: begin
                mem_addr       = cpu_mem_addr;
                mem_ro_addr2   = cpu_mem_ro_addr2;
                mem_we         = cpu_mem_we;
                mem_write_size = cpu_mem_write_size;
                mem_wd         = cpu_mem_wd;
            end
            default: begin
            end
        endcase
    end

    assign cpu_reset  = r_cpu_reset;
    assign done       = r_done;
    assign error      = r_error;
    assign load_count = r_count;

endmodule

// File: tb/tb_mem_load_ctrl.sv
// Bench for mem_load_ctrl: byte-array memory model, a table of directed loads, hand-written
// reset/handover sequences and randomized loads with stalls and readback corruption.
module tb_mem_load_ctrl;

    localparam logic [31:0] START  = 32'h8000_0000;
    localparam int          MSIZE  = 8192;
    localparam int          BUDGET = 40000;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [31:0] load_len;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready;
    logic [31:0] cpu_mem_addr;
    logic [31:0] cpu_mem_ro_addr2;
    logic        cpu_mem_we;
    logic [1:0]  cpu_mem_write_size;
    logic [31:0] cpu_mem_wd;
    logic [31:0] mem_addr;
    logic [31:0] mem_ro_addr2;
    logic        mem_we;
    logic [1:0]  mem_write_size;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd2;
    logic        cpu_reset;
    logic        done;
    logic        error;
    logic [31:0] load_count;

    mem_load_ctrl #(
        .START_ADDR (START),
        .MEM_SIZE   (MSIZE),
        .VERIFY     (1'b1)
    ) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .start              (start),
        .load_len           (load_len),
        .s_valid            (s_valid),
        .s_data             (s_data),
        .s_ready            (s_ready),
        .cpu_mem_addr       (cpu_mem_addr),
        .cpu_mem_ro_addr2   (cpu_mem_ro_addr2),
        .cpu_mem_we         (cpu_mem_we),
        .cpu_mem_write_size (cpu_mem_write_size),
        .cpu_mem_wd         (cpu_mem_wd),
        .mem_addr           (mem_addr),
        .mem_ro_addr2       (mem_ro_addr2),
        .mem_we             (mem_we),
        .mem_write_size     (mem_write_size),
        .mem_wd             (mem_wd),
        .mem_rd2            (mem_rd2),
        .cpu_reset          (cpu_reset),
        .done               (done),
        .error              (error),
        .load_count         (load_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // memory model: byte array, plus the load id that last wrote each byte
    logic [7:0]  tb_mem [0:MSIZE-1];
    int          wgen   [0:MSIZE-1];
    int          load_id    = 0;
    int          n_writes   = 0;
    int          oob_writes = 0;
    logic [31:0] last_waddr = '0;
    logic [31:0] wr_off;
    int          wr_nbytes;
    logic [31:0] ro_off;
    logic        corrupt_en;
    logic [31:0] corrupt_at;

    assign wr_off    = mem_addr - START;
    assign wr_nbytes = (mem_write_size == 2'd0) ? 1 : (mem_write_size == 2'd1) ? 2 : 4;
    assign ro_off    = mem_ro_addr2 - START;

    always @(posedge clk) begin
        if (mem_we) begin
            n_writes   <= n_writes + 1;
            last_waddr <= mem_addr;
            if (wr_off >= 32'(MSIZE)) begin
                oob_writes <= oob_writes + 1;
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (b < wr_nbytes && (wr_off + 32'(b)) < 32'(MSIZE)) begin
                        tb_mem[13'(wr_off + 32'(b))] <= mem_wd[8*b +: 8];
                        wgen[13'(wr_off + 32'(b))]   <= load_id;
                    end
                end
            end
        end
    end

    always_comb begin
        mem_rd2 = '0;
        for (int b = 0; b < 4; b++) begin
            mem_rd2[8*b +: 8] = tb_mem[13'(ro_off + 32'(b))] ^
                ((corrupt_en && (ro_off + 32'(b) == corrupt_at)) ? 8'hFC : 8'h00);
        end
    end

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_bytes [0:MSIZE-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset_n    = 1'b0;
        start      = 1'b0;
        s_valid    = 1'b0;
        cpu_mem_we = 1'b0;
        #2;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // mode 0: back-to-back, 1: valid toggles 1/0, 2: random 40% stalls
    task automatic do_load(input string tag, input int len_in, input int mode, input int cor,
                           output int lat, output int wc);
        int  lq;
        int  cyc;
        int  sent;
        int  viol;
        int  bad;
        int  wr_base;
        bit  exp_rdy;
        bit  v;
        lq         = (len_in > MSIZE) ? MSIZE : len_in;
        load_id    = load_id + 1;
        corrupt_en = (cor >= 0);
        corrupt_at = 32'(cor);
        wr_base    = n_writes;
        @(negedge clk);
        start    = 1'b1;
        load_len = 32'(len_in);
        s_valid  = 1'b0;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        sent  = 0;
        wc    = 0;
        viol  = 0;
        check({tag, ".err_cleared"}, {31'b0, error}, 32'd0);
        check({tag, ".count_cleared"}, load_count, 32'd0);
        while (!(done === 1'b1 || error === 1'b1) && cyc < BUDGET) begin
            exp_rdy = (sent < lq);
            if (exp_rdy) begin
                case (mode)
                    0:       v = 1'b1;
                    1:       v = (wc % 2 == 0);
                    default: v = ($urandom_range(99) >= 40);
                endcase
                s_valid = v;
                s_data  = exp_bytes[sent];
                wc++;
            end else begin
                s_valid = 1'b0;
            end
            #1;
            if (exp_rdy) begin
                if (s_ready !== 1'b1 || mem_we !== s_valid ||
                    (s_valid && (mem_addr !== START + 32'(sent) || mem_wd !== {24'h0, s_data} ||
                                 mem_write_size !== 2'd0)))
                    viol++;
            end else if (s_ready !== 1'b0 || mem_we !== 1'b0) begin
                viol++;
            end
            if (s_valid) sent++;
            @(negedge clk);
            cyc++;
        end
        s_valid    = 1'b0;
        corrupt_en = 1'b0;
        check({tag, ".no_timeout"}, {31'b0, cyc < BUDGET}, 32'd1);
        check({tag, ".handshake_viol"}, 32'(viol), 32'd0);
        bad = 0;
        for (int i = 0; i < lq; i++)
            if (wgen[i] != load_id || tb_mem[i] !== exp_bytes[i]) bad++;
        check({tag, ".mem_content_bad"}, 32'(bad), 32'd0);
        check({tag, ".n_writes"}, 32'(n_writes - wr_base), 32'(lq));
        if (lq > 0) check({tag, ".last_waddr"}, last_waddr, START + 32'(lq - 1));
        check({tag, ".load_count"}, load_count, 32'(lq));
        lat = cyc;
    endtask

    typedef struct {
        bit pre_reset;
        int load_len;
        int mode;
        int cor;
        int exp_count;
        bit exp_done;
        bit exp_err;
        int exp_lat;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int  lat;
        int  wc;
        int  len;
        int  cor;
        int  lq;
        bit  prev_err;
        string tag;

        vecs[0] = '{1'b1, 16,    0, -1, 16,   1'b1, 1'b0, 33};
        vecs[1] = '{1'b1, 4,     1, -1, 4,    1'b1, 1'b0, 12};
        vecs[2] = '{1'b1, 8,     0,  3, 8,    1'b0, 1'b1, 17};
        vecs[3] = '{1'b0, 8,     0, -1, 8,    1'b1, 1'b0, 17};
        vecs[4] = '{1'b1, 0,     0, -1, 0,    1'b1, 1'b0, 1};
        vecs[5] = '{1'b1, 1,     1, -1, 1,    1'b1, 1'b0, 3};
        vecs[6] = '{1'b1, 10000, 0, -1, 8192, 1'b1, 1'b0, 16385};
        vecs[7] = '{1'b1, 5,     0,  4, 5,    1'b0, 1'b1, 11};

        reset_n            = 1'b0;
        start              = 1'b0;
        load_len           = '0;
        s_valid            = 1'b0;
        s_data             = '0;
        cpu_mem_addr       = '0;
        cpu_mem_ro_addr2   = '0;
        cpu_mem_we         = 1'b0;
        cpu_mem_write_size = '0;
        cpu_mem_wd         = '0;
        corrupt_en         = 1'b0;
        corrupt_at         = '0;

        #12;
        check("rst.s_ready",   {31'b0, s_ready},   32'd0);
        check("rst.done",      {31'b0, done},      32'd0);
        check("rst.error",     {31'b0, error},     32'd0);
        check("rst.cpu_reset", {31'b0, cpu_reset}, 32'd1);
        check("rst.load_count", load_count,        32'd0);
        check("rst.mem_we",    {31'b0, mem_we},    32'd0);
        check("rst.mem_addr",  mem_addr,           START);
        check("rst.mem_ro",    mem_ro_addr2,       START);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            tag = $sformatf("vec%0d", i);
            if (vecs[i].pre_reset) apply_reset();
            for (int j = 0; j < MSIZE; j++) exp_bytes[j] = 8'(j) ^ 8'(j >> 8) ^ 8'(i * 16);
            if (i == 0) for (int j = 0; j < 16; j++) exp_bytes[j] = 8'(j);
            if (i == 2) exp_bytes[3] = 8'h03;
            do_load(tag, vecs[i].load_len, vecs[i].mode, vecs[i].cor, lat, wc);
            check({tag, ".exp_count"}, load_count, 32'(vecs[i].exp_count));
            check({tag, ".done"},      {31'b0, done},      {31'b0, vecs[i].exp_done});
            check({tag, ".error"},     {31'b0, error},     {31'b0, vecs[i].exp_err});
            check({tag, ".cpu_reset"}, {31'b0, cpu_reset}, {31'b0, !vecs[i].exp_done});
            check({tag, ".latency"},   32'(lat),           32'(vecs[i].exp_lat));
        end

        // reset in the middle of WRITE, then a reload from START_ADDR
        apply_reset();
        for (int j = 0; j < 16; j++) exp_bytes[j] = 8'(j * 7 + 3);
        @(negedge clk);
        start    = 1'b1;
        load_len = 32'd16;
        @(negedge clk);
        start = 1'b0;
        for (int j = 0; j < 5; j++) begin
            s_valid = 1'b1;
            s_data  = exp_bytes[j];
            @(negedge clk);
        end
        s_valid = 1'b1;
        s_data  = exp_bytes[5];
        #1;
        check("midrst.count_before", load_count, 32'd5);
        #1;
        reset_n = 1'b0;
        #1;
        check("midrst.s_ready",   {31'b0, s_ready},   32'd0);
        check("midrst.cpu_reset", {31'b0, cpu_reset}, 32'd1);
        check("midrst.load_count", load_count,        32'd0);
        check("midrst.mem_we",    {31'b0, mem_we},    32'd0);
        check("midrst.mem_addr",  mem_addr,           START);
        s_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int j = 0; j < 16; j++) exp_bytes[j] = 8'(j) ^ 8'h5A;
        do_load("reload", 16, 0, -1, lat, wc);
        check("reload.latency", 32'(lat), 32'd33);
        check("reload.done", {31'b0, done}, 32'd1);

        // CPU owns the memory in RUN; start has no effect
        @(negedge clk);
        cpu_mem_addr       = 32'h8000_0100;
        cpu_mem_ro_addr2   = 32'h8000_0040;
        cpu_mem_we         = 1'b1;
        cpu_mem_write_size = 2'd2;
        cpu_mem_wd         = 32'hDEAD_BEEF;
        start              = 1'b1;
        load_len           = 32'd4;
        #1;
        check("run.mem_addr",   mem_addr,                    32'h8000_0100);
        check("run.mem_ro",     mem_ro_addr2,                32'h8000_0040);
        check("run.mem_we",     {31'b0, mem_we},             32'd1);
        check("run.write_size", {30'b0, mem_write_size},     32'd2);
        check("run.mem_wd",     mem_wd,                      32'hDEAD_BEEF);
        check("run.s_ready",    {31'b0, s_ready},            32'd0);
        @(negedge clk);
        start      = 1'b0;
        cpu_mem_we = 1'b0;
        #1;
        check("run.start_ignored_done", {31'b0, done},      32'd1);
        check("run.start_ignored_rst",  {31'b0, cpu_reset}, 32'd0);
        check("run.start_ignored_cnt",  load_count,         32'd16);
        check("run.word_written", {tb_mem[259], tb_mem[258], tb_mem[257], tb_mem[256]}, 32'hDEAD_BEEF);

        // randomized loads with stalls and occasional readback corruption
        prev_err = 1'b0;
        for (int n = 0; n < 10; n++) begin
            tag = $sformatf("rnd%0d", n);
            if (!prev_err) apply_reset();
            len = ($urandom_range(9) == 0) ? 0 : int'($urandom_range(40, 1));
            cor = (len > 0 && $urandom_range(2) == 0) ? int'($urandom_range(len - 1)) : -1;
            lq  = len;
            for (int j = 0; j < lq; j++) exp_bytes[j] = 8'($urandom);
            do_load(tag, len, 2, cor, lat, wc);
            prev_err = (cor >= 0);
            check({tag, ".error"},     {31'b0, error},     {31'b0, prev_err});
            check({tag, ".done"},      {31'b0, done},      {31'b0, !prev_err});
            check({tag, ".cpu_reset"}, {31'b0, cpu_reset}, {31'b0, prev_err});
            check({tag, ".latency"},   32'(lat),           32'(1 + wc + lq));
        end

        check("oob_writes", 32'(oob_writes), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
